// File: rtl/seg14_scroll_mux.sv
// seg14_scroll_mux: scanned 14-segment digit driver with message buffer, static/scroll/blink/off modes
module seg14_scroll_mux #(
  parameter int DIGITS        = 12,
  parameter int MSG_LEN       = 32,
  parameter int SCAN_DIV      = 1,
  parameter int SCROLL_FRAMES = 64,
  parameter int AW            = $clog2(MSG_LEN),
  parameter int LW            = $clog2(MSG_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [13:0]       wr_data,
  input  logic [LW-1:0]     msg_len,
  input  logic [1:0]        mode,
  output logic [DIGITS-1:0] sel,
  output logic [13:0]       segm,
  output logic              frame_done
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam int FW = SCROLL_FRAMES > 1 ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [AW:0] ML = MSG_LEN;
  typedef enum logic [1:0] {M_STATIC, M_SCROLL, M_BLINK, M_OFF} mode_t;
  logic [13:0] mem [MSG_LEN];
  logic [PW-1:0] pre;
  logic [DW-1:0] dig, dig_n;
  logic [FW-1:0] fc;
  logic [AW-1:0] offset, ptr, base, off_n, ptr_n;
  logic [LW-1:0] len_q, nl, e_len;
  logic phase, phase_n, e_phase, tick, wrap, fc_wrap;
  mode_t mode_q, e_mode;
  logic [13:0] stat_g, glyph;
  // At a frame wrap the new frame's length/mode/offset/phase are used
  // combinationally so digit 0 already shows the freshly latched settings.
  always_comb begin
    tick = pre == PW'(SCAN_DIV - 1);
    wrap = tick && dig == DW'(DIGITS - 1);
    dig_n = wrap ? '0 : dig + DW'(1);
    fc_wrap = fc == FW'(SCROLL_FRAMES - 1);
    nl = msg_len == '0 ? LW'(1) : msg_len > LW'(MSG_LEN) ? LW'(MSG_LEN) : msg_len;
    base = LW'(offset) >= nl ? '0 : offset;
    off_n = fc_wrap && mode_q == M_SCROLL ? (LW'(base) + LW'(1) == nl ? '0 : base + AW'(1)) : base;
    phase_n = mode_q == M_BLINK && (fc_wrap ? !phase : phase);
    e_len = wrap ? nl : len_q;
    e_mode = wrap ? mode_t'(mode) : mode_q;
    e_phase = wrap ? phase_n : phase;
    ptr_n = wrap ? off_n : (LW'(ptr) + LW'(1) == len_q ? '0 : ptr + AW'(1));
    stat_g = LW'(dig_n) < e_len ? mem[AW'(dig_n)] : '0;
    glyph = e_mode == M_SCROLL ? mem[ptr_n] : e_mode == M_BLINK && e_phase ? '0 : stat_g;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      dig <= DW'(DIGITS - 1);
      fc <= '0;
      offset <= '0;
      phase <= 1'b0;
      len_q <= LW'(1);
      mode_q <= M_STATIC;
      ptr <= '0;
      sel <= '0;
      segm <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      frame_done <= wrap;
      if (wr_en && {1'b0, wr_addr} < ML) mem[wr_addr] <= wr_data;
      if (tick) begin
        dig <= dig_n;
        ptr <= ptr_n;
        sel <= e_mode == M_OFF ? '0 : DIGITS'(1) << dig_n;
        segm <= e_mode == M_OFF ? '0 : glyph;
      end
      if (wrap) begin
        len_q <= nl;
        mode_q <= mode_t'(mode);
        offset <= off_n;
        fc <= fc_wrap ? '0 : fc + FW'(1);
      end
      phase <= wrap ? phase_n : phase && mode_q == M_BLINK;
    end
endmodule

// File: tb/tb_seg14_scroll_mux.sv
// tb_seg14_scroll_mux: directed frame tables plus random traffic against a frame-level reference model
module tb_seg14_scroll_mux;
  localparam int D = 4, ML = 8, SD = 2, SF = 2;
  logic clk = 0, rst_n = 0, wr_en = 0;
  logic [2:0] wr_addr = 0;
  logic [13:0] wr_data = 0;
  logic [3:0] msg_len = 0;
  logic [1:0] mode = 0;
  logic [3:0] sel;
  logic [13:0] segm;
  logic frame_done;
  int total = 0, bad = 0;

  seg14_scroll_mux #(.DIGITS(D), .MSG_LEN(ML), .SCAN_DIV(SD), .SCROLL_FRAMES(SF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .mode(mode), .sel(sel), .segm(segm), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  md;
    logic [3:0]  ln;
    logic [55:0] g;
    logic [15:0] s;
  } rec_t;

  // reference model: clocks since reset -> slot -> digit/frame, frame state updated per boundary
  int k, nb, m_off, m_len, m_mode;
  bit m_ph, m_fd;
  logic [13:0] mb [ML];
  logic [3:0] m_sel;
  logic [13:0] m_segm;

  task automatic model_reset();
    k = 0; nb = 0; m_off = 0; m_len = 1; m_mode = 0; m_ph = 0; m_fd = 0;
    m_sel = 0; m_segm = 0;
    foreach (mb[i]) mb[i] = 0;
  endtask

  task automatic model_edge();
    int n, d, nl;
    bit fw;
    logic [13:0] st;
    if (!rst_n) return;
    k++;
    m_fd = 0;
    if (k % SD == 0) begin
      n = k / SD;
      d = (n - 1) % D;
      if (d == 0) begin
        nl = msg_len == 0 ? 1 : (msg_len > ML ? ML : int'(msg_len));
        fw = (nb % SF) == SF - 1;
        if (m_off >= nl) m_off = 0;
        if (fw && m_mode == 1) m_off = (m_off + 1) % nl;
        m_ph = (m_mode == 2) && (fw ? !m_ph : m_ph);
        m_len = nl;
        m_mode = int'(mode);
        nb++;
        m_fd = 1;
      end
      st = d < m_len ? mb[d] : 14'd0;
      if (m_mode == 3) begin
        m_sel = 0;
        m_segm = 0;
      end else begin
        m_sel = 4'(1 << d);
        m_segm = m_mode == 1 ? mb[(m_off + d) % m_len] : (m_mode == 2 && m_ph) ? 14'd0 : st;
      end
    end
    if (wr_en) mb[wr_addr] = wr_data;
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model", {sel, segm, frame_done}, {m_sel, m_segm, m_fd});
  endtask

  task automatic wait_fd();
    int i = 0;
    while (frame_done !== 1'b1 && i < 40) begin
      step();
      i++;
    end
    check("fd_wait", 64'(frame_done), 64'd1);
  endtask

  task automatic cap_frame(output logic [55:0] g, output logic [15:0] s);
    wait_fd();
    for (int j = 0; j < 4; j++) begin
      g[55 - 14 * j -: 14] = segm;
      s[15 - 4 * j -: 4] = sel;
      if (j < 3) begin
        step();
        step();
      end
    end
  endtask

  task automatic run_rec(rec_t r, string nm);
    logic [55:0] g;
    logic [15:0] s;
    mode = r.md;
    msg_len = r.ln;
    cap_frame(g, s);
    check({nm, "_segm"}, 64'(g), 64'(r.g));
    check({nm, "_sel"}, 64'(s), 64'(r.s));
  endtask

  task automatic async_rst();
    #3 rst_n = 0;
    #1 check("async_rst", 64'({sel, segm, frame_done}), 64'd0);
    model_reset();
    step();
    rst_n = 1;
  endtask

  function automatic logic [55:0] fr(int a, int b, int c, int d);
    return {14'(a), 14'(b), 14'(c), 14'(d)};
  endfunction

  function automatic rec_t mk(int md, int ln, logic [55:0] g, logic [15:0] s);
    return '{2'(md), 4'(ln), g, s};
  endfunction

  initial begin
    logic [3:0] scan_sel [10] = '{0, 1, 1, 2, 2, 4, 4, 8, 8, 1};
    bit scan_fd [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int sc [20] = '{1234, 1234, 2345, 2345, 3451, 3451, 4512, 4512, 5123, 5123,
                    1234, 1234, 2345, 2345, 3451, 3451, 4512, 4512, 5123, 1231};
    logic [13:0] gl [4] = '{14'h3BC0, 14'h2012, 14'h2DC0, 14'h3C12};
    logic [55:0] all4;
    rec_t tab [$];
    all4 = fr(gl[0], gl[1], gl[2], gl[3]);
    tab.push_back(mk(0, 2, fr(gl[0], gl[1], 0, 0), 16'h1248));
    tab.push_back(mk(0, 0, fr(gl[0], 0, 0, 0), 16'h1248));
    tab.push_back(mk(0, 15, all4, 16'h1248));
    tab.push_back(mk(2, 4, all4, 16'h1248));
    tab.push_back(mk(2, 4, all4, 16'h1248));
    tab.push_back(mk(2, 4, 56'd0, 16'h1248));
    tab.push_back(mk(2, 4, 56'd0, 16'h1248));
    tab.push_back(mk(2, 4, all4, 16'h1248));
    tab.push_back(mk(2, 4, all4, 16'h1248));
    tab.push_back(mk(3, 4, 56'd0, 16'h0000));

    model_reset();
    repeat (3) step();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("scan_sel%0d", i), 64'(sel), 64'(scan_sel[i]));
      check($sformatf("scan_fd%0d", i), 64'(frame_done), 64'(scan_fd[i]));
      check($sformatf("scan_segm%0d", i), 64'(segm), 64'd0);
    end

    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = gl[i];
      step();
    end
    wr_en = 0;
    foreach (tab[i]) run_rec(tab[i], $sformatf("tab%0d", i));

    mode = 0; msg_len = 4;
    wait_fd();
    wr_en = 1; wr_addr = 1; wr_data = 14'h1555;
    step();
    wr_en = 0;
    step();
    check("wr_before_slot", 64'(segm), 64'h1555);
    wait_fd();
    step();
    wr_en = 1; wr_addr = 1; wr_data = 14'h0AAA;
    step();
    wr_en = 0;
    check("wr_same_edge_old", 64'(segm), 64'h1555);
    wait_fd();
    step();
    step();
    check("wr_visible", 64'(segm), 64'h0AAA);

    mode = 0; msg_len = 5;
    async_rst();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 14'(i + 1);
      step();
    end
    wr_en = 0;
    foreach (sc[i])
      run_rec(mk(1, i == 19 ? 3 : 5, fr(sc[i] / 1000, sc[i] / 100 % 10, sc[i] / 10 % 10, sc[i] % 10), 16'h1248),
              $sformatf("scroll%0d", i));

    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        mode = 2'($urandom_range(0, 3));
        msg_len = 4'($urandom_range(0, 15));
      end
      wr_en = ($urandom % 4) == 0;
      wr_addr = 3'($urandom);
      wr_data = ($urandom % 5 == 0) ? 14'd0 : 14'($urandom);
      if (i == 1500) async_rst();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
